// File: rtl/line_clear_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : line_clear_seq_if
//  Description : Handshake and board bus between the game FSM / board
//                (master) and the line-clear controller (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface line_clear_seq_if #(
    parameter int ROWS  = 23,
    parameter int CNT_W = 3,
    parameter int TOT_W = 16
);
    logic              start;
    logic [ROWS-1:0]   rowfull;
    logic [ROWS-1:0]   rowshift;
    logic              shift_en;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  lines_cleared;
    logic [TOT_W-1:0]  total_lines;
    logic              overrun;

    // Game FSM and board side
    modport master (
        output start, rowfull,
        input  rowshift, shift_en, busy, done, lines_cleared, total_lines, overrun
    );

    // Line-clear controller side
    modport slave (
        input  start, rowfull,
        output rowshift, shift_en, busy, done, lines_cleared, total_lines, overrun
    );
endinterface
`default_nettype wire

// File: rtl/line_clear_seq.sv
`default_nettype none
// ============================================================================
//  Module      : line_clear_seq
//  Description : Sequential line-clear controller. After a piece locks it
//                repeatedly finds the highest-index full row, issues a
//                one-cycle shift strobe with a row mask, waits for the board
//                to settle and rescans, until no row is full. Counts the
//                lines of each sequence and keeps a saturating running total.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_clear_seq #(
    parameter int ROWS   = 23,
    parameter int IDX_W  = 5,
    parameter int CNT_W  = 3,
    parameter int TOT_W  = 16,
    parameter int SETTLE = 1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    line_clear_seq_if.slave     bus
);

    // Pass counter needs to reach ROWS itself, so give it one spare bit.
    localparam int c_PASS_W = IDX_W + 1;
    localparam int c_WAIT_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam int c_SUM_W  = TOT_W + 1;

    localparam logic [c_PASS_W-1:0] c_PASS_MAX = c_PASS_W'(ROWS);
    localparam logic [c_WAIT_W-1:0] c_SETTLE   = c_WAIT_W'(SETTLE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SCAN  = 3'd1,
        S_SHIFT = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    logic [ROWS-1:0]       r_rowshift;
    logic                  r_shift_en;
    logic                  r_busy;
    logic                  r_done;
    logic [CNT_W-1:0]      r_lines;
    logic [TOT_W-1:0]      r_total;
    logic                  r_overrun;
    logic [c_PASS_W-1:0]   r_pass;
    logic [c_WAIT_W-1:0]   r_wait;

    logic                  w_any_full;
    logic [IDX_W-1:0]      w_idx;
    logic [ROWS-1:0]       w_mask;
    logic [c_SUM_W-1:0]    w_sum;

    // Highest-index full row: later (higher) indices overwrite earlier ones.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (bus.rowfull[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    assign w_any_full = |bus.rowfull;

    // Shift mask covers the cleared row and every row above it.
    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_mask
            assign w_mask[gi] = (IDX_W'(gi) <= w_idx);
        end
    endgenerate

    // One extra bit catches the carry for total saturation.
    assign w_sum = {1'b0, r_total} + {{(c_SUM_W-CNT_W){1'b0}}, r_lines};

    // Controller FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rowshift <= '0;
            r_shift_en <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_lines    <= '0;
            r_total    <= '0;
            r_overrun  <= 1'b0;
            r_pass     <= '0;
            r_wait     <= '0;
        end else begin
            // Strobes and the mask only live for a single cycle.
            r_done     <= 1'b0;
            r_shift_en <= 1'b0;
            r_rowshift <= '0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_SCAN;
                        r_busy  <= 1'b1;
                        r_lines <= '0;
                        r_pass  <= '0;
                    end
                end
                S_SCAN: begin
                    if (!w_any_full) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (r_pass == c_PASS_MAX) begin
                        // A row is still full after every row has been shifted:
                        // the board is not responding, give up.
                        r_overrun <= 1'b1;
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        r_rowshift <= w_mask;
                        r_shift_en <= 1'b1;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_lines != {CNT_W{1'b1}}) begin
                        r_lines <= r_lines + 1'b1;
                    end
                    r_pass  <= r_pass + 1'b1;
                    r_wait  <= c_SETTLE;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Counter reaching zero on this decrement ends the wait.
                    if (r_wait <= c_WAIT_W'(1)) begin
                        r_wait  <= '0;
                        r_state <= S_SCAN;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                S_DONE: begin
                    if (w_sum[TOT_W]) begin
                        r_total <= {TOT_W{1'b1}};
                    end else begin
                        r_total <= w_sum[TOT_W-1:0];
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rowshift      = r_rowshift;
    assign bus.shift_en      = r_shift_en;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.lines_cleared = r_lines;
    assign bus.total_lines   = r_total;
    assign bus.overrun       = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_line_clear_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_clear_seq
//  Description : Directed self-checking bench for line_clear_seq. A second
//                instance with a 4-bit total shares all inputs to exercise
//                total saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_line_clear_seq;

    localparam int c_ROWS = 23;

    logic              clk;
    logic              rst;
    logic              start;
    logic [c_ROWS-1:0] board;
    bit                model_en;

    int n_checks;
    int n_errors;

    line_clear_seq_if #(.ROWS(c_ROWS), .CNT_W(3), .TOT_W(16)) bus  ();
    line_clear_seq_if #(.ROWS(c_ROWS), .CNT_W(3), .TOT_W(4))  bus4 ();

    assign bus.start    = start;
    assign bus.rowfull  = board;
    assign bus4.start   = start;
    assign bus4.rowfull = board;

    line_clear_seq #(.ROWS(c_ROWS), .IDX_W(5), .CNT_W(3), .TOT_W(16), .SETTLE(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    line_clear_seq #(.ROWS(c_ROWS), .IDX_W(5), .CNT_W(3), .TOT_W(4), .SETTLE(1)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simplified board: the row at the top of the shift mask stops being full.
    always @(negedge clk) begin
        int hi;
        if (model_en && bus.shift_en) begin
            hi = -1;
            for (int i = 0; i < c_ROWS; i++) begin
                if (bus.rowshift[i]) hi = i;
            end
            if (hi >= 0) board[hi] = 1'b0;
        end
    end

    // Runs one sequence from a start pulse. cyc is the done cycle counted
    // with the start cycle as 0 (0 on timeout). Optionally pulses start at
    // loop step pulse_at, or in the cycle done is high.
    task automatic run_seq(input int pulse_at, input bit pulse_on_done,
                           output int cyc, output int nshift,
                           output logic [c_ROWS-1:0] m0, output logic [c_ROWS-1:0] m1,
                           output logic busy_first, output bit idle_ok);
        bit got_done;
        got_done   = 0;
        cyc        = 0;
        nshift     = 0;
        m0         = '0;
        m1         = '0;
        busy_first = 1'b0;
        idle_ok    = 1;
        start      = 1'b1;
        for (int n = 0; n < 300 && !got_done; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (n == 0) busy_first = bus.busy;
            if (bus.shift_en) begin
                if (nshift == 0) m0 = bus.rowshift;
                if (nshift == 1) m1 = bus.rowshift;
                nshift++;
            end
            if (bus.done) begin
                got_done = 1;
                cyc = n + 1;
                if (pulse_on_done) start = 1'b1;
            end else if (n == pulse_at) begin
                start = 1'b1;
            end
        end
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (bus.busy || bus.done || bus.shift_en) idle_ok = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        board = '0;
        model_en = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.shift_en !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: busy/done/shift_en=%b%b%b expected 000",
                     bus.busy, bus.done, bus.shift_en);
        end
        n_checks++;
        if (bus.rowshift !== '0 || bus.lines_cleared !== '0) begin
            n_errors++;
            $display("FAIL reset_data: rowshift=%h lines=%0d expected 0/0",
                     bus.rowshift, bus.lines_cleared);
        end
        n_checks++;
        if (bus.total_lines !== '0 || bus.overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_total: total=%0d overrun=%b expected 0/0",
                     bus.total_lines, bus.overrun);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_no_rows();
        int cyc, ns;
        logic [c_ROWS-1:0] m0, m1;
        logic bf;
        bit ok;
        board = '0;
        model_en = 1;
        run_seq(-1, 0, cyc, ns, m0, m1, bf, ok);
        n_checks++;
        if (bf !== 1'b1) begin
            n_errors++;
            $display("FAIL empty_busy: busy=%b expected 1", bf);
        end
        n_checks++;
        if (cyc != 2 || ns != 0) begin
            n_errors++;
            $display("FAIL empty_latency: done_cycle=%0d shifts=%0d expected 2/0", cyc, ns);
        end
        n_checks++;
        if (bus.lines_cleared !== 3'd0 || bus.total_lines !== 16'd0) begin
            n_errors++;
            $display("FAIL empty_counts: lines=%0d total=%0d expected 0/0",
                     bus.lines_cleared, bus.total_lines);
        end
    endtask

    // Rows 19..22 full, four times; mid-sequence and done-cycle start pulses.
    task automatic test_four_rows();
        int cyc, ns;
        logic [c_ROWS-1:0] m0, m1;
        logic bf;
        bit ok;
        int exp_tot [4] = '{4, 8, 12, 16};
        int exp_tot4[4] = '{4, 8, 12, 15};
        model_en = 1;
        for (int r = 0; r < 4; r++) begin
            board = 23'h780000;
            run_seq((r == 0) ? 3 : -1, (r == 1), cyc, ns, m0, m1, bf, ok);
            n_checks++;
            if (ns != 4 || bus.lines_cleared !== 3'd4 || cyc != 14) begin
                n_errors++;
                $display("FAIL four_run%0d: shifts=%0d lines=%0d done_cycle=%0d expected 4/4/14",
                         r, ns, bus.lines_cleared, cyc);
            end
            n_checks++;
            if (m0 !== 23'h7FFFFF || m1 !== 23'h3FFFFF) begin
                n_errors++;
                $display("FAIL four_masks%0d: %h %h expected 7fffff 3fffff", r, m0, m1);
            end
            n_checks++;
            if (!ok) begin
                n_errors++;
                $display("FAIL four_idle%0d: activity after done, expected idle", r);
            end
            n_checks++;
            if (bus.total_lines !== 16'(exp_tot[r]) || bus4.total_lines !== 4'(exp_tot4[r])) begin
                n_errors++;
                $display("FAIL four_total%0d: total=%0d total4=%0d expected %0d/%0d",
                         r, bus.total_lines, bus4.total_lines, exp_tot[r], exp_tot4[r]);
            end
        end
    endtask

    task automatic test_two_rows();
        int cyc, ns;
        logic [c_ROWS-1:0] m0, m1;
        logic bf;
        bit ok;
        board = (23'h1 << 22) | (23'h1 << 20);
        model_en = 1;
        run_seq(-1, 0, cyc, ns, m0, m1, bf, ok);
        n_checks++;
        if (m0 !== 23'h7FFFFF || m1 !== 23'h1FFFFF || ns != 2) begin
            n_errors++;
            $display("FAIL two_masks: %h %h shifts=%0d expected 7fffff 1fffff 2", m0, m1, ns);
        end
        n_checks++;
        if (cyc != 8 || bus.lines_cleared !== 3'd2) begin
            n_errors++;
            $display("FAIL two_timing: done_cycle=%0d lines=%0d expected 8/2", cyc, bus.lines_cleared);
        end
        n_checks++;
        if (bus.total_lines !== 16'd18 || bus4.total_lines !== 4'd15) begin
            n_errors++;
            $display("FAIL two_total: total=%0d total4=%0d expected 18/15",
                     bus.total_lines, bus4.total_lines);
        end
    endtask

    task automatic test_row0();
        int cyc, ns;
        logic [c_ROWS-1:0] m0, m1;
        logic bf;
        bit ok;
        board = 23'h1;
        model_en = 1;
        run_seq(-1, 0, cyc, ns, m0, m1, bf, ok);
        n_checks++;
        if (m0 !== 23'h000001 || ns != 1 || cyc != 5) begin
            n_errors++;
            $display("FAIL row0: mask=%h shifts=%0d done_cycle=%0d expected 000001/1/5", m0, ns, cyc);
        end
        n_checks++;
        if (bus.total_lines !== 16'd19 || bus.overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL row0_total: total=%0d overrun=%b expected 19/0",
                     bus.total_lines, bus.overrun);
        end
    endtask

    // Row 22 never empties: every pass shifts, then the pass limit trips.
    task automatic test_overrun();
        int cyc, ns;
        logic [c_ROWS-1:0] m0, m1;
        logic bf;
        bit ok;
        model_en = 0;
        board = 23'h1 << 22;
        run_seq(-1, 0, cyc, ns, m0, m1, bf, ok);
        n_checks++;
        if (ns != 23 || cyc != 71) begin
            n_errors++;
            $display("FAIL overrun_shifts: shifts=%0d done_cycle=%0d expected 23/71", ns, cyc);
        end
        n_checks++;
        if (bus.overrun !== 1'b1 || bus.lines_cleared !== 3'd7) begin
            n_errors++;
            $display("FAIL overrun_flag: overrun=%b lines=%0d expected 1/7",
                     bus.overrun, bus.lines_cleared);
        end
        n_checks++;
        if (bus.total_lines !== 16'd26) begin
            n_errors++;
            $display("FAIL overrun_total: total=%0d expected 26", bus.total_lines);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        bit done_seen;
        model_en = 0;
        board = 23'h1 << 22;
        seen = 0;
        start = 1'b1;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (bus.shift_en) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL midrst_shift: shift_en seen=0 expected 1");
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.shift_en !== 1'b0 || bus.busy !== 1'b0 || bus.rowshift !== '0) begin
            n_errors++;
            $display("FAIL midrst_async: shift_en=%b busy=%b rowshift=%h expected 0/0/0",
                     bus.shift_en, bus.busy, bus.rowshift);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        done_seen = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) done_seen = 1;
        end
        n_checks++;
        if (done_seen) begin
            n_errors++;
            $display("FAIL midrst_nodone: done/busy seen=1 expected 0");
        end
        n_checks++;
        if (bus.total_lines !== '0 || bus.overrun !== 1'b0 || bus4.total_lines !== '0) begin
            n_errors++;
            $display("FAIL midrst_clear: total=%0d overrun=%b total4=%0d expected 0/0/0",
                     bus.total_lines, bus.overrun, bus4.total_lines);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        start    = 1'b0;
        board    = '0;
        model_en = 0;
        test_reset();
        test_no_rows();
        test_four_rows();
        test_two_rows();
        test_row0();
        test_overrun();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
